// File: rtl/vme_ram_pkg.sv
// Shared constants and FSM encoding for the VME event RAM write-side controller.
package vme_ram_pkg;

  localparam int VME_ADDR_W  = 10;
  localparam int TRIG_LOST_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/vme_trig_edge.sv
// Trigger register and rising-edge detector shared by the L2 trigger consumers.
module vme_trig_edge (
  input  logic clk,
  input  logic rst,
  input  logic trig_in,
  output logic trig_edge
);

  logic trig_q;

  always_ff @(posedge clk) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trig_in;
  end

  // A level held high produces exactly one edge.
  assign trig_edge = trig_in & ~trig_q;

endmodule

// File: rtl/vme_ram_capture_ctrl.sv
// Ping-pong write-side controller for the VME event RAM, with a readout release handshake.
// Optional trigger-loss counter is built when VME_RAM_TRIG_LOST_EN is defined.
import vme_ram_pkg::*;

module vme_ram_capture_ctrl #(
  parameter int ADDR_W = VME_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trig_in,
  input  logic [ADDR_W-1:0]      burst_len,
  input  logic                   rd_done,
  output logic                   wr_ena,
  output logic [ADDR_W:0]        wr_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   buf_valid,
  output logic                   rd_bank,
  output logic [ADDR_W-1:0]      rd_len,
  output logic [TRIG_LOST_W-1:0] trig_lost
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_WRITE = WRITE;

  logic [0:0]        state;
  logic              wr_bank;
  logic              rd_ptr;
  logic [1:0]        full;
  logic [1:0]        full_next;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] len_reg [2];
  logic              done_r;
  logic              trig_edge;
  logic              start;
  logic              burst_end;
  logic              release_ok;

  vme_trig_edge u_trig_edge (
    .clk       (clk),
    .rst       (rst),
    .trig_in   (trig_in),
    .trig_edge (trig_edge)
  );

  // Banks fill and drain in strict alternation, so full[wr_bank] implies both are full.
  assign start     = (state == S_IDLE) && trig_edge && !full[wr_bank];
  assign burst_end = (state == S_WRITE) && (offset == len_reg[wr_bank]);

  // Readout handshake: buf_valid/rd_bank/rd_len describe the oldest full bank; a rd_done
  // pulse while buf_valid is high releases it, a rd_done with nothing full is ignored.
  assign release_ok = rd_done && full[rd_ptr];

  always_comb begin
    full_next = full;
    if (burst_end)  full_next[wr_bank] = 1'b1;
    if (release_ok) full_next[rd_ptr]  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_bank    <= 1'b0;
      rd_ptr     <= 1'b0;
      full       <= 2'b00;
      offset     <= '0;
      len_reg[0] <= '0;
      len_reg[1] <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= burst_end;
      full   <= full_next;
      if (release_ok) rd_ptr <= ~rd_ptr;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_reg[wr_bank] <= burst_len;
            offset           <= '0;
            state            <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (burst_end) begin
            state   <= S_IDLE;
            wr_bank <= ~wr_bank;
            offset  <= '0;
          end else begin
            offset <= offset + ADDR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef VME_RAM_TRIG_LOST_EN
  logic                   lose;
  logic [TRIG_LOST_W-1:0] lost_cnt;

  assign lose = (state == S_IDLE) && trig_edge && full[wr_bank];

  always_ff @(posedge clk) begin
    if (rst)                      lost_cnt <= '0;
    else if (lose && !(&lost_cnt)) lost_cnt <= lost_cnt + TRIG_LOST_W'(1);
  end

  assign trig_lost = lost_cnt;
`else
  assign trig_lost = '0;
`endif

  assign wr_ena    = (state == S_WRITE);
  assign busy      = (state == S_WRITE);
  assign wr_addr   = {wr_bank, offset};
  assign done      = done_r;
  assign buf_valid = |full;
  assign rd_bank   = rd_ptr;
  assign rd_len    = len_reg[rd_ptr];

endmodule

// File: tb/tb_vme_ram_capture_ctrl.sv
// Table-driven bench for vme_ram_capture_ctrl plus directed multi-cycle sequences.
module tb_vme_ram_capture_ctrl;

  localparam int AW = 10;

`ifdef VME_RAM_TRIG_LOST_EN
  localparam bit LOST_EN = 1'b1;
`else
  localparam bit LOST_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          trig_in;
  logic [AW-1:0] burst_len;
  logic          rd_done;
  logic          wr_ena;
  logic [AW:0]   wr_addr;
  logic          busy;
  logic          done;
  logic          buf_valid;
  logic          rd_bank;
  logic [AW-1:0] rd_len;
  logic [15:0]   trig_lost;

  int checks = 0;
  int errors = 0;

  vme_ram_capture_ctrl #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .trig_in   (trig_in),
    .burst_len (burst_len),
    .rd_done   (rd_done),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .done      (done),
    .buf_valid (buf_valid),
    .rd_bank   (rd_bank),
    .rd_len    (rd_len),
    .trig_lost (trig_lost)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          trig;
    logic [AW-1:0] len;
    logic          rdd;
    logic          rs;
    logic          e_wr;
    logic [AW:0]   e_addr;
    logic          e_done;
    logic          e_bv;
    logic          e_rb;
    logic [AW-1:0] e_rl;
    logic [15:0]   e_lost;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic trig, input int len, input logic rdd, input logic rs,
                              input logic e_wr, input int e_addr, input logic e_done,
                              input logic e_bv, input logic e_rb, input int e_rl, input int e_lost);
    vec_t v;
    v.trig = trig;  v.len = AW'(len);  v.rdd = rdd;  v.rs = rs;
    v.e_wr = e_wr;  v.e_addr = (AW+1)'(e_addr);  v.e_done = e_done;
    v.e_bv = e_bv;  v.e_rb = e_rb;  v.e_rl = AW'(e_rl);
    v.e_lost = LOST_EN ? 16'(e_lost) : 16'd0;
    return v;
  endfunction

  // driver: apply inputs away from the edge, sample 1 time unit after it
  task automatic step(input logic trig, input int len, input logic rdd, input logic rs);
    @(negedge clk);
    trig_in   = trig;
    burst_len = AW'(len);
    rd_done   = rdd;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_wr, input logic [AW:0] e_addr,
                            input logic e_done, input logic e_bv, input logic e_rb,
                            input logic [AW-1:0] e_rl, input logic [15:0] e_lost);
    check({tag, ".wr_ena"},    32'(wr_ena),    32'(e_wr));
    check({tag, ".busy"},      32'(busy),      32'(e_wr));
    if (e_wr) check({tag, ".wr_addr"}, 32'(wr_addr), 32'(e_addr));
    check({tag, ".done"},      32'(done),      32'(e_done));
    check({tag, ".buf_valid"}, 32'(buf_valid), 32'(e_bv));
    if (e_bv) begin
      check({tag, ".rd_bank"}, 32'(rd_bank),   32'(e_rb));
      check({tag, ".rd_len"},  32'(rd_len),    32'(e_rl));
    end
    check({tag, ".trig_lost"}, 32'(trig_lost), 32'(e_lost));
  endtask

  initial begin
    trig_in = 1'b0; burst_len = '0; rd_done = 1'b0; rst = 1'b1;

    //               trig len  rdd rst | wr addr   done bv rb rl lost
    vecs[0]  = mk(0, 0,    0, 1,   0, 0,      0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0,    0, 0,   0, 0,      0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 3,    0, 0,   1, 'h000,  0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 3,    0, 0,   1, 'h001,  0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 3,    0, 0,   1, 'h002,  0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 3,    0, 0,   1, 'h003,  0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 3,    0, 0,   0, 0,      1, 1, 0, 3, 0);
    vecs[7]  = mk(1, 0,    0, 0,   1, 'h400,  0, 1, 0, 3, 0);
    vecs[8]  = mk(0, 0,    0, 0,   0, 0,      1, 1, 0, 3, 0);
    vecs[9]  = mk(1, 5,    0, 0,   0, 0,      0, 1, 0, 3, 1);
    vecs[10] = mk(0, 5,    1, 0,   0, 0,      0, 1, 1, 0, 1);
    vecs[11] = mk(1, 2,    0, 0,   1, 'h000,  0, 1, 1, 0, 1);
    vecs[12] = mk(0, 2,    0, 0,   1, 'h001,  0, 1, 1, 0, 1);
    vecs[13] = mk(1, 7,    0, 0,   1, 'h002,  0, 1, 1, 0, 1);
    vecs[14] = mk(0, 7,    0, 0,   0, 0,      1, 1, 1, 0, 1);
    vecs[15] = mk(1, 4,    1, 0,   0, 0,      0, 1, 0, 2, 2);
    vecs[16] = mk(0, 4,    1, 0,   0, 0,      0, 0, 0, 0, 2);
    vecs[17] = mk(0, 4,    1, 0,   0, 0,      0, 0, 0, 0, 2);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].trig, int'(vecs[i].len), vecs[i].rdd, vecs[i].rs);
      check_outs($sformatf("vec%0d", i), vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_done,
                 vecs[i].e_bv, vecs[i].e_rb, vecs[i].e_rl, vecs[i].e_lost);
    end

    // full-depth burst into bank 1 with the trigger held for 50 cycles
    step(1'b1, 1023, 1'b0, 1'b0);
    check("full.wr_ena0", 32'(wr_ena), 32'd1);
    check("full.addr0", 32'(wr_addr), 32'h400);
    for (int i = 1; i < 1024; i++) begin
      step(i < 50, 1023, 1'b0, 1'b0);
      check("full.wr_ena", 32'(wr_ena), 32'd1);
      check("full.addr", 32'(wr_addr), 32'h400 + 32'(i));
    end
    step(1'b0, 1023, 1'b0, 1'b0);
    check_outs("full_end", 1'b0, '0, 1'b1, 1'b1, 1'b1, AW'(1023), LOST_EN ? 16'd2 : 16'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1023, 1'b0, 1'b0);
      check("full.no_rerun", 32'(wr_ena), 32'd0);
      check("full.done_once", 32'(done), 32'd0);
    end
    step(1'b0, 0, 1'b1, 1'b0);
    check("full.release", 32'(buf_valid), 32'd0);

    // reset at offset 5 of a 16-word burst into bank 0
    step(1'b1, 15, 1'b0, 1'b0);
    check("rst.addr0", 32'(wr_addr), 32'h000);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 15, 1'b0, 1'b0);
      check("rst.addr", 32'(wr_addr), 32'(i));
    end
    step(1'b0, 15, 1'b0, 1'b1);
    check_outs("rst_mid", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 16'd0);
    check("rst_mid.wr_addr", 32'(wr_addr), 32'd0);
    check("rst_mid.rd_bank", 32'(rd_bank), 32'd0);
    check("rst_mid.rd_len", 32'(rd_len), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 15, 1'b0, 1'b0);
      check_outs("rst_after", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 16'd0);
    end

    // rd_done landing on the same edge as a burst completion
    step(1'b1, 0, 1'b0, 1'b0);
    check_outs("co_b0", 1'b1, 'h000, 1'b0, 1'b0, 1'b0, '0, 16'd0);
    step(1'b0, 0, 1'b0, 1'b0);
    check_outs("co_b0_end", 1'b0, '0, 1'b1, 1'b1, 1'b0, AW'(0), 16'd0);
    step(1'b1, 1, 1'b0, 1'b0);
    check_outs("co_b1_w0", 1'b1, 'h400, 1'b0, 1'b1, 1'b0, AW'(0), 16'd0);
    step(1'b0, 1, 1'b0, 1'b0);
    check_outs("co_b1_w1", 1'b1, 'h401, 1'b0, 1'b1, 1'b0, AW'(0), 16'd0);
    step(1'b0, 1, 1'b1, 1'b0);
    check_outs("co_end", 1'b0, '0, 1'b1, 1'b1, 1'b1, AW'(1), 16'd0);
    step(1'b0, 1, 1'b1, 1'b0);
    check_outs("co_drain", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 16'd0);
    check("co_drain.rd_bank", 32'(rd_bank), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
